// File: rtl/sm3_msg_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sm3_msg_fetch_if                                                     |
// | Register-file, SRAM and compression-core signals of the fetch stage. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface sm3_msg_fetch_if #(
   parameter int AW = 13
);
   logic          ENABLE;
   logic [AW-1:0] SAR_ADDR;
   logic [AW-1:0] BSR;
   logic          MEM_RD;
   logic [AW-1:0] MEM_ADDR;
   logic [31:0]   MEM_RDATA;
   logic          BLK_VALID;
   logic          BLK_READY;
   logic [511:0]  BLK_DATA;
   logic          BLK_FIRST;
   logic          BLK_LAST;
   logic          CORE_DONE;
   logic          BUSY;
   logic          SET_STR;

   modport slave (
      input  ENABLE, SAR_ADDR, BSR, MEM_RDATA, BLK_READY, CORE_DONE,
      output MEM_RD, MEM_ADDR, BLK_VALID, BLK_DATA, BLK_FIRST, BLK_LAST, BUSY, SET_STR
   );

   modport master (
      output ENABLE, SAR_ADDR, BSR, MEM_RDATA, BLK_READY, CORE_DONE,
      input  MEM_RD, MEM_ADDR, BLK_VALID, BLK_DATA, BLK_FIRST, BLK_LAST, BUSY, SET_STR
   );
endinterface
`default_nettype wire

// File: rtl/sm3_msg_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sm3_msg_fetch                                                        |
// | Fetches BSR 512-bit blocks from SRAM and hands them to the SM3 core. |
// | Optional macro SM3_BYTESWAP_EN byte-reverses each fetched word.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sm3_msg_fetch #(
   parameter int BLK_WORDS = 16,
   parameter int AW        = 13
) (
   input  logic           AHB_HCLK,
   input  logic           AHB_HRESETN,
   sm3_msg_fetch_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_HAND  = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [4:0]    WORDS_C  = 5'(BLK_WORDS);
   localparam logic [4:0]    LASTW_C  = 5'(BLK_WORDS - 1);
   localparam logic [AW-1:0] ONE_C    = AW'(1);

   state_t        state_q;
   logic          enable_q;
   logic [AW-1:0] addr_ptr_q;
   logic [AW-1:0] blk_left_q;
   logic [AW-1:0] mem_addr_q;
   logic [4:0]    rd_cnt_q;
   logic [4:0]    wd_cnt_q;
   logic          cap_q;
   logic          mem_rd_q;
   logic          blk_valid_q;
   logic          blk_first_q;
   logic          blk_last_q;
   logic          busy_q;
   logic          set_str_q;
   logic [511:0]  blk_data_q;
   logic [31:0]   word_d;
   logic          start;

   assign start = bus.ENABLE & ~enable_q;

`ifdef SM3_BYTESWAP_EN
   assign word_d = {bus.MEM_RDATA[7:0], bus.MEM_RDATA[15:8],
                    bus.MEM_RDATA[23:16], bus.MEM_RDATA[31:24]};
`else
   assign word_d = bus.MEM_RDATA;
`endif

   always_ff @(posedge AHB_HCLK) begin
      if (!AHB_HRESETN) begin
         state_q     <= S_IDLE;
         enable_q    <= 1'b0;
         addr_ptr_q  <= '0;
         blk_left_q  <= '0;
         mem_addr_q  <= '0;
         rd_cnt_q    <= '0;
         wd_cnt_q    <= '0;
         cap_q       <= 1'b0;
         mem_rd_q    <= 1'b0;
         blk_valid_q <= 1'b0;
         blk_first_q <= 1'b0;
         blk_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         set_str_q   <= 1'b0;
         blk_data_q  <= '0;
      end else begin
         enable_q <= bus.ENABLE;
         // SRAM data returns one cycle after the strobe that requested it
         cap_q    <= mem_rd_q;
         if (state_q != S_IDLE && !bus.ENABLE) begin
            state_q     <= S_IDLE;
            mem_rd_q    <= 1'b0;
            blk_valid_q <= 1'b0;
            blk_first_q <= 1'b0;
            blk_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            set_str_q   <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start) begin
                     if (bus.BSR != '0) begin
                        state_q     <= S_FETCH;
                        busy_q      <= 1'b1;
                        blk_first_q <= 1'b1;
                        blk_left_q  <= bus.BSR;
                        mem_rd_q    <= 1'b1;
                        mem_addr_q  <= bus.SAR_ADDR;
                        addr_ptr_q  <= bus.SAR_ADDR + ONE_C;
                        rd_cnt_q    <= 5'd1;
                        wd_cnt_q    <= 5'd0;
                     end else begin
                        state_q   <= S_DONE;
                        set_str_q <= 1'b1;
                     end
                  end
               end
               S_FETCH: begin
                  if (rd_cnt_q != WORDS_C) begin
                     mem_rd_q   <= 1'b1;
                     mem_addr_q <= addr_ptr_q;
                     addr_ptr_q <= addr_ptr_q + ONE_C;
                     rd_cnt_q   <= rd_cnt_q + 5'd1;
                  end else begin
                     mem_rd_q <= 1'b0;
                  end
                  if (cap_q) begin
                     blk_data_q <= {blk_data_q[479:0], word_d};
                     wd_cnt_q   <= wd_cnt_q + 5'd1;
                     if (wd_cnt_q == LASTW_C) begin
                        state_q     <= S_HAND;
                        blk_valid_q <= 1'b1;
                        blk_last_q  <= (blk_left_q == ONE_C);
                     end
                  end
               end
               S_HAND: begin
                  if (bus.BLK_READY) begin
                     state_q     <= S_WAIT;
                     blk_valid_q <= 1'b0;
                     blk_last_q  <= 1'b0;
                  end
               end
               S_WAIT: begin
                  if (bus.CORE_DONE) begin
                     blk_left_q <= blk_left_q - ONE_C;
                     if (blk_left_q == ONE_C) begin
                        state_q   <= S_DONE;
                        busy_q    <= 1'b0;
                        set_str_q <= 1'b1;
                     end else begin
                        // next block continues from where the previous one ended
                        state_q     <= S_FETCH;
                        blk_first_q <= 1'b0;
                        mem_rd_q    <= 1'b1;
                        mem_addr_q  <= addr_ptr_q;
                        addr_ptr_q  <= addr_ptr_q + ONE_C;
                        rd_cnt_q    <= 5'd1;
                        wd_cnt_q    <= 5'd0;
                     end
                  end
               end
               S_DONE: begin
                  set_str_q <= 1'b1;
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.MEM_RD    = mem_rd_q;
   assign bus.MEM_ADDR  = mem_addr_q;
   assign bus.BLK_VALID = blk_valid_q;
   assign bus.BLK_DATA  = blk_data_q;
   assign bus.BLK_FIRST = blk_first_q;
   assign bus.BLK_LAST  = blk_last_q;
   assign bus.BUSY      = busy_q;
   assign bus.SET_STR   = set_str_q;
endmodule
`default_nettype wire

// File: tb/tb_sm3_msg_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sm3_msg_fetch                                                     |
// | Self-checking bench for sm3_msg_fetch with SRAM and core models.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sm3_msg_fetch;
   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   sm3_msg_fetch_if #(.AW(13)) bus ();

   sm3_msg_fetch #(.BLK_WORDS(16), .AW(13)) dut (
      .AHB_HCLK    (clk),
      .AHB_HRESETN (rstn),
      .bus         (bus.slave)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] mem [8192];
   logic [12:0] rdq [$];
   int          xfers;

   always @(posedge clk) begin
      if (bus.MEM_RD === 1'b1) begin
         bus.MEM_RDATA <= mem[bus.MEM_ADDR];
         rdq.push_back(bus.MEM_ADDR);
      end
      if (bus.BLK_VALID === 1'b1 && bus.BLK_READY === 1'b1) xfers++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   function automatic void chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endfunction

   function automatic void chki(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endfunction

   function automatic logic [31:0] pk(input logic [31:0] w);
`ifdef SM3_BYTESWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   // block b of a message is 16 consecutive words starting at sar + 16*b (mod 8192)
   function automatic logic [511:0] model_blk(input logic [12:0] sar, input int b);
      logic [511:0] r;
      r = '0;
      for (int i = 0; i < 16; i++)
         r[511-32*i -: 32] = pk(mem[(int'(sar) + 16*b + i) % 8192]);
      return r;
   endfunction

   task automatic run_job(input logic [12:0] sar, input logic [12:0] bsr, input int stall,
                          input int lat, input logic use_exp, input logic [31:0] exp_top,
                          input logic [31:0] exp_bot);
      int k;
      int nbad;
      logic [511:0] held;
      rdq.delete();
      xfers = 0;
      bus.SAR_ADDR = sar;
      bus.BSR      = bsr;
      bus.ENABLE   = 1'b1;
      if (bsr == 13'd0) begin
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chki("bsr0_set_str", int'(bus.SET_STR), 1);
            chki("bsr0_busy", int'(bus.BUSY), 0);
         end
      end else begin
         for (int b = 0; b < int'(bsr); b++) begin
            k = 0;
            do begin
               @(negedge clk);
               k++;
            end while (bus.BLK_VALID !== 1'b1 && k < 100);
            if (b == 0) begin
               chki("valid_latency", k, 18);
               bus.SAR_ADDR = ~sar;
               bus.BSR      = bsr + 13'd5;
            end else begin
               chki("valid_seen", int'(bus.BLK_VALID), 1);
            end
            chk("blk_data", bus.BLK_DATA, model_blk(sar, b));
            chki("blk_first", int'(bus.BLK_FIRST), (b == 0) ? 1 : 0);
            chki("blk_last", int'(bus.BLK_LAST), (b == int'(bsr) - 1) ? 1 : 0);
            chki("busy_hand", int'(bus.BUSY), 1);
            if (use_exp && b == 0) chk("top_word", 512'(bus.BLK_DATA[511:480]), 512'(exp_top));
            if (use_exp && b == int'(bsr) - 1) chk("bot_word", 512'(bus.BLK_DATA[31:0]), 512'(exp_bot));
            held = bus.BLK_DATA;
            for (int s = 0; s < stall; s++) begin
               @(negedge clk);
               chki("stall_valid", int'(bus.BLK_VALID), 1);
               chk("stall_data", bus.BLK_DATA, held);
            end
            bus.BLK_READY = 1'b1;
            @(negedge clk);
            bus.BLK_READY = 1'b0;
            chki("valid_drop", int'(bus.BLK_VALID), 0);
            for (int c = 0; c < lat; c++) @(negedge clk);
            bus.CORE_DONE = 1'b1;
            @(negedge clk);
            bus.CORE_DONE = 1'b0;
            chki("set_str_after_done", int'(bus.SET_STR), (b == int'(bsr) - 1) ? 1 : 0);
            chki("busy_after_done", int'(bus.BUSY), (b == int'(bsr) - 1) ? 0 : 1);
         end
         nbad = 0;
         for (int i = 0; i < rdq.size(); i++)
            if (int'(rdq[i]) != (int'(sar) + i) % 8192) nbad++;
         chki("rd_count", rdq.size(), 16 * int'(bsr));
         chki("rd_addr_errors", nbad, 0);
         chki("transfers", xfers, int'(bsr));
      end
      bus.ENABLE = 1'b0;
      @(negedge clk);
      chki("set_str_clear", int'(bus.SET_STR), 0);
      chki("busy_clear", int'(bus.BUSY), 0);
   endtask

   typedef struct {
      logic [12:0] sar;
      logic [12:0] bsr;
      int          stall;
      int          lat;
      logic        pre_en;
      logic [31:0] pre;
      logic [31:0] exp_top;
      logic [31:0] exp_bot;
   } vec_t;

   vec_t tbl [5];

   initial begin
      bus.ENABLE    = 1'b0;
      bus.SAR_ADDR  = '0;
      bus.BSR       = '0;
      bus.BLK_READY = 1'b0;
      bus.CORE_DONE = 1'b0;
      bus.MEM_RDATA = '0;
      xfers         = 0;
      for (int a = 0; a < 8192; a++) mem[a] = 32'(a);

      tbl[0] = '{13'h0010, 13'd1, 0, 0, 1'b0, 32'h0, pk(32'h10),   pk(32'h1F)};
      tbl[1] = '{13'h1FF8, 13'd2, 1, 2, 1'b0, 32'h0, pk(32'h1FF8), pk(32'h17)};
      tbl[2] = '{13'h0100, 13'd0, 0, 0, 1'b0, 32'h0, 32'h0,        32'h0};
      tbl[3] = '{13'h0040, 13'd1, 5, 3, 1'b0, 32'h0, pk(32'h40),   pk(32'h4F)};
`ifdef SM3_BYTESWAP_EN
      tbl[4] = '{13'h0200, 13'd1, 0, 1, 1'b1, 32'h11223344, 32'h44332211, pk(32'h20F)};
`else
      tbl[4] = '{13'h0200, 13'd1, 0, 1, 1'b1, 32'h11223344, 32'h11223344, pk(32'h20F)};
`endif

      repeat (3) @(negedge clk);
      chk("reset_outputs",
          512'({bus.MEM_RD, bus.MEM_ADDR, bus.BLK_VALID, bus.BLK_FIRST, bus.BLK_LAST,
                bus.BUSY, bus.SET_STR}), 512'(0));
      chk("reset_blk_data", bus.BLK_DATA, 512'(0));
      rstn = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 5; v++) begin
         if (tbl[v].pre_en) mem[tbl[v].sar] = tbl[v].pre;
         run_job(tbl[v].sar, tbl[v].bsr, tbl[v].stall, tbl[v].lat, 1'b1,
                 tbl[v].exp_top, tbl[v].exp_bot);
         repeat (2) @(negedge clk);
      end

      // abort during the seventh read of block 0, then a clean re-run
      rdq.delete();
      bus.SAR_ADDR = 13'h0300;
      bus.BSR      = 13'd2;
      bus.ENABLE   = 1'b1;
      repeat (7) @(negedge clk);
      chki("abort_rd7_strobe", int'(bus.MEM_RD), 1);
      chki("abort_rd7_addr", int'(bus.MEM_ADDR), 32'h306);
      bus.ENABLE = 1'b0;
      @(negedge clk);
      chki("abort_mem_rd", int'(bus.MEM_RD), 0);
      chki("abort_busy", int'(bus.BUSY), 0);
      bus.CORE_DONE = 1'b1;
      @(negedge clk);
      bus.CORE_DONE = 1'b0;
      repeat (3) @(negedge clk);
      chki("abort_no_set_str", int'(bus.SET_STR), 0);
      chki("abort_no_valid", int'(bus.BLK_VALID), 0);
      run_job(13'h0300, 13'd1, 0, 0, 1'b1, pk(32'h300), pk(32'h30F));
      repeat (2) @(negedge clk);

      for (int a = 0; a < 8192; a++) mem[a] = $urandom;
      for (int j = 0; j < 12; j++) begin
         run_job(13'($urandom), 13'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 4)), 1'b0, 32'h0, 32'h0);
         repeat (int'($urandom_range(1, 3))) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
